oscillator_bin_sequencer: RTL and testbench

Upstream scheduler for the shared oscillator accumulator in the frequency machine. Once per audio sample tick, it sweeps the bin index across all active bins and reads each bin's gain from an external synchronous gain RAM. It drives the accumulator with aligned freq_number/gain/accumulate strobes, closes each sweep with a single save pulse, and then advances the frame counter.

---
 rtl/oscillator_bin_sequencer_pkg.sv | 16 +
 rtl/oscillator_bin_sequencer.sv | 119 +++++++++++
 tb/tb_oscillator_bin_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/oscillator_bin_sequencer_pkg.sv
// Frequency machine shared package.
// Provides the sweep FSM state encoding, the fixed sweep overhead in cycles
// (DRAIN + SAVE beyond one cycle per bin), and the compression word width.
package oscillator_bin_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    SAVE  = 2'd3
  } seq_state_e;

  localparam int unsigned SWEEP_OVERHEAD = 2;
  localparam int unsigned COMP_W         = 12;

endpackage

// File: rtl/oscillator_bin_sequencer.sv
// Oscillator bin sequencer: once per accepted sample tick, sweeps bin indices
// 0..N_BINS-1 through an external synchronous gain RAM and presents aligned
// freq_number/gain/accumulate strobes to the shared accumulator, then issues
// one save pulse and advances the frame counter.
//
// Ports:
//   clk_i            system clock
//   srst_n_i         synchronous active-low reset
//   sample_tick_i    one-cycle strobe per audio sample
//   compression_i    compression coefficient, latched on tick acceptance
//   gain_rd_addr_o   gain RAM read address (bin index being issued)
//   gain_rd_data_i   gain RAM data, valid one cycle after the address
//   accumulate_o     accumulator add strobe
//   save_o           end-of-sweep strobe
//   freq_number_o    bin index aligned with accumulate_o
//   frame_counter_o  frame counter, constant during a sweep, wraps mod 2**FCW
//   freq_gain_o      gain aligned with accumulate_o
//   compression_o    compression value latched for the current sweep
//   busy_o           sweep in progress
//   overrun_o        sticky: tick arrived while busy
//
// Optional feature macro: OSC_SEQ_SKIP_ZERO_GAIN_EN
//   When defined, accumulate_o is suppressed for bins whose gain is zero;
//   sweep timing and save position are unchanged.
module oscillator_bin_sequencer
  import oscillator_bin_sequencer_pkg::*;
#(
  parameter int unsigned AW     = 10,
  parameter int unsigned FCW    = 10,
  parameter int unsigned DW     = 18,
  parameter int unsigned N_BINS = 512
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic              sample_tick_i,
  input  logic [COMP_W-1:0] compression_i,
  output logic [AW-1:0]     gain_rd_addr_o,
  input  logic [DW-1:0]     gain_rd_data_i,
  output logic              accumulate_o,
  output logic              save_o,
  output logic [AW-1:0]     freq_number_o,
  output logic [FCW-1:0]    frame_counter_o,
  output logic [DW-1:0]     freq_gain_o,
  output logic [COMP_W-1:0] compression_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam logic [AW-1:0] LAST_BIN = AW'(N_BINS - 1);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic              valid_q;
  logic [AW-1:0]     num_q;
  logic [DW-1:0]     gain_hold_q;
  logic [FCW-1:0]    frame_q;
  logic [COMP_W-1:0] comp_q;
  logic              overrun_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_tick_i) state_d = SWEEP;
      SWEEP:   if (addr_q == LAST_BIN) state_d = DRAIN;
      DRAIN:   state_d = SAVE;
      SAVE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      num_q       <= '0;
      gain_hold_q <= '0;
      frame_q     <= '0;
      comp_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // One-stage delay of the address/valid pair lines up with RAM latency.
      valid_q <= (state_q == SWEEP);
      if (state_q == SWEEP) num_q <= addr_q;
      if (valid_q) gain_hold_q <= gain_rd_data_i;
      unique case (state_q)
        IDLE: if (sample_tick_i) begin
          addr_q <= '0;
          comp_q <= compression_i;
        end
        SWEEP: if (addr_q != LAST_BIN) addr_q <= addr_q + 1'b1;
        SAVE:  frame_q <= frame_q + 1'b1;
        default: ;
      endcase
      if (sample_tick_i && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  // The RAM's output register is the alignment stage for the gain, so the
  // data is passed straight through on accumulate cycles and held otherwise.
  always_comb begin
    freq_gain_o = valid_q ? gain_rd_data_i : gain_hold_q;
`ifdef OSC_SEQ_SKIP_ZERO_GAIN_EN
    accumulate_o = valid_q && (gain_rd_data_i != '0);
`else
    accumulate_o = valid_q;
`endif
  end

  assign gain_rd_addr_o  = addr_q;
  assign freq_number_o   = num_q;
  assign frame_counter_o = frame_q;
  assign compression_o   = comp_q;
  assign busy_o          = (state_q != IDLE);
  assign save_o          = (state_q == SAVE);
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_oscillator_bin_sequencer.sv
// Scoreboard bench for oscillator_bin_sequencer with N_BINS=4, FCW=3.
module tb_oscillator_bin_sequencer;
  import oscillator_bin_sequencer_pkg::*;

  localparam int AW = 10;
  localparam int FCW = 3;
  localparam int DW = 18;
  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              srst_n;
  logic              tick;
  logic [COMP_W-1:0] compression;
  logic [AW-1:0]     gain_rd_addr;
  logic [DW-1:0]     gain_rd_data;
  logic              accumulate;
  logic              save;
  logic [AW-1:0]     freq_number;
  logic [FCW-1:0]    frame_counter;
  logic [DW-1:0]     freq_gain;
  logic [COMP_W-1:0] compression_q;
  logic              busy;
  logic              overrun;

  oscillator_bin_sequencer #(.AW(AW), .FCW(FCW), .DW(DW), .N_BINS(NB)) dut (
    .clk_i(clk), .srst_n_i(srst_n), .sample_tick_i(tick),
    .compression_i(compression), .gain_rd_addr_o(gain_rd_addr),
    .gain_rd_data_i(gain_rd_data), .accumulate_o(accumulate), .save_o(save),
    .freq_number_o(freq_number), .frame_counter_o(frame_counter),
    .freq_gain_o(freq_gain), .compression_o(compression_q), .busy_o(busy),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous gain RAM model, one cycle read latency.
  logic [DW-1:0] mem [0:NB-1];
  always @(posedge clk) gain_rd_data <= mem[int'(gain_rd_addr) % NB];

  typedef struct {
    bit                is_save;
    int                cyc;
    logic [AW-1:0]     num;
    logic [DW-1:0]     gain;
    logic [FCW-1:0]    fc;
    logic [COMP_W-1:0] comp;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  logic [FCW-1:0] fc_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input int c, input int k);
    exp_t e;
`ifdef OSC_SEQ_SKIP_ZERO_GAIN_EN
    if (mem[k] == '0) return;
`endif
    e.is_save = 1'b0; e.cyc = c; e.num = AW'(k); e.gain = mem[k];
    e.fc = '0; e.comp = '0;
    q.push_back(e);
  endtask

  task automatic push_save(input int c, input logic [COMP_W-1:0] comp);
    exp_t e;
    e.is_save = 1'b1; e.cyc = c; e.num = '0; e.gain = '0;
    e.fc = fc_model; e.comp = comp;
    q.push_back(e);
  endtask

  task automatic check_all_zero();
    check("rst_acc", 32'(accumulate), 0);
    check("rst_save", 32'(save), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_addr", 32'(gain_rd_addr), 0);
    check("rst_num", 32'(freq_number), 0);
    check("rst_gain", 32'(freq_gain), 0);
    check("rst_frame", 32'(frame_counter), 0);
    check("rst_comp", 32'(compression_q), 0);
  endtask

  // Called at a cycle with the DUT idle; returns at cycle t+NB+3.
  // extra != 0 raises a second tick at cycle t+extra.
  task automatic sweep(input logic [COMP_W-1:0] comp, input int extra);
    int t;
    t = cyc;
    tick = 1'b1;
    compression = comp;
    for (int k = 0; k < NB; k++) push_acc(t + 2 + k, k);
    push_save(t + NB + SWEEP_OVERHEAD, comp);
    for (int i = 1; i <= NB + 2; i++) begin
      step();
      tick = 1'b0;
      compression = ~comp;
      check("busy", 32'(busy), 1);
      if (i <= NB) check("addr", 32'(gain_rd_addr), 32'(i - 1));
      check("comp_hold", 32'(compression_q), 32'(comp));
      if (extra != 0 && i == extra + 1) check("overrun_set", 32'(overrun), 1);
      if (i == extra) tick = 1'b1;
    end
    step();
    tick = 1'b0;
    fc_model = fc_model + 1'b1;
    check("busy_drop", 32'(busy), 0);
    check("frame_adv", 32'(frame_counter), 32'(fc_model));
  endtask

  always @(negedge clk) begin
    if (accumulate && save) check("acc_save_excl", 1, 0);
    if (accumulate || save) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output cyc=%0d actual acc=%0b save=%0b required none",
                 cyc, accumulate, save);
      end else begin
        mon_e = q.pop_front();
        check("out_kind", 32'(save), 32'(mon_e.is_save));
        check("out_cycle", cyc, mon_e.cyc);
        if (mon_e.is_save) begin
          check("save_frame", 32'(frame_counter), 32'(mon_e.fc));
          check("save_comp", 32'(compression_q), 32'(mon_e.comp));
        end else begin
          check("acc_num", 32'(freq_number), 32'(mon_e.num));
          check("acc_gain", 32'(freq_gain), 32'(mon_e.gain));
        end
      end
    end
  end

  initial begin
    int t;
    srst_n = 1'b0;
    tick = 1'b0;
    compression = '0;
    mem[0] = 18'd11; mem[1] = 18'd22; mem[2] = 18'd33; mem[3] = 18'd44;
    repeat (3) step();
    check_all_zero();
    // Tick while reset is still asserted must be ignored.
    tick = 1'b1;
    step();
    srst_n = 1'b1;
    tick = 1'b0;
    check("tick_in_reset", 32'(busy), 0);
    while (cyc < 10) step();

    // Single sweep at cycle 10, then two contiguous sweeps.
    sweep(12'h123, 0);
    sweep(12'h456, 0);
    sweep(12'h789, 0);
    check("no_overrun_contig", 32'(overrun), 0);

    // Remaining sweeps for frame counter wrap (9 total); one has a tick at SAVE.
    sweep(12'h001, 0);
    sweep(12'h002, 0);
    sweep(12'h003, NB + 2);
    check("overrun_at_save", 32'(overrun), 1);
    repeat (3) step();
    sweep(12'h004, 4);
    repeat (8) step();
    sweep(12'h005, 0);
    sweep(12'h006, 0);
    check("frame_wrapped", 32'(frame_counter), 1);

    // Reset while issuing bin 2.
    repeat (2) step();
    t = cyc;
    tick = 1'b1;
    compression = 12'hABC;
    push_acc(t + 2, 0);
    push_acc(t + 3, 1);
    step();
    tick = 1'b0;
    check("abort_addr0", 32'(gain_rd_addr), 0);
    step();
    step();
    check("abort_addr2", 32'(gain_rd_addr), 2);
    srst_n = 1'b0;
    step();
    check_all_zero();
    srst_n = 1'b1;
    fc_model = '0;
    repeat (4) step();

    // Clean sweep after reset with zero gains present.
    mem[0] = 18'd5; mem[1] = 18'd0; mem[2] = 18'd7; mem[3] = 18'd0;
    sweep(12'hFED, 0);
    check("no_overrun_after_rst", 32'(overrun), 0);

    repeat (10) step();
    check("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
